// File: rtl/motoro3_commutation_seq.sv
// ---------------------------------------------------------------------------
// motoro3_commutation_seq
//
// Six-step (trapezoidal) commutation sequencer for a 3-phase bridge. It drives
// the per-phase enable and high/low select of three half-bridge MOS drivers.
// Every pattern change passes through an all-off dead interval of DEADTIME
// cycles, so no leg switches directly from one pattern to the next.
//
// Optional feature (macro MOTORO3_STEP_TIMER_EN):
//   Adds a 16-bit stepPeriod input. An internal period counter runs in DRIVE
//   and issues an automatic step every stepPeriod DRIVE cycles. stepPeriod=0
//   disables the timer. Without the macro, steps come only from stepReq.
//
// Ports:
//   clk          in   10 MHz system clock, rising edge
//   rst          in   synchronous reset, active-high
//   start        in   level, leave IDLE and begin driving at stepIdx
//   stop         in   level, return to IDLE with all legs off
//   dirCw        in   1 = increment step index, 0 = decrement
//   stepReq      in   single-cycle pulse, advance one commutation step
//   fault        in   level, driver fault, highest priority
//   faultClr     in   pulse, leave FAULT when fault is low
//   stepPeriod   in   [15:0] auto-step period (timer build only)
//   phEnable     out  [2:0] per-phase driver enable, bit0=A bit1=B bit2=C
//   phH1L0       out  [2:0] per-phase select, 1 = high side, 0 = low side
//   stepIdx      out  [2:0] current commutation step, 0..5
//   busy         out  high in DEAD or DRIVE
//   faultLatched out  high in FAULT
// ---------------------------------------------------------------------------
module motoro3_commutation_seq #(
    parameter int DEADTIME = 20,
    parameter int DT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        dirCw,
    input  logic        stepReq,
    input  logic        fault,
    input  logic        faultClr,
`ifdef MOTORO3_STEP_TIMER_EN
    input  logic [15:0] stepPeriod,
`endif
    output logic [2:0]  phEnable,
    output logic [2:0]  phH1L0,
    output logic [2:0]  stepIdx,
    output logic        busy,
    output logic        faultLatched
);

    typedef enum logic [1:0] {S_IDLE, S_DEAD, S_DRIVE, S_FAULT} state_t;

    // Counter counts DEADTIME-1 down to 0, giving DEADTIME all-off cycles.
    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME - 1);

    state_t          state_q, state_d;
    logic [DT_W-1:0] dead_cnt_q, dead_cnt_d;
    logic [2:0]      step_idx_q, step_idx_d;
    logic [2:0]      ph_enable_q, ph_enable_d;
    logic [2:0]      ph_h1l0_q, ph_h1l0_d;
    logic            busy_q, busy_d;
    logic            fault_latched_q, fault_latched_d;

    logic [1:0]      hi_ph, lo_ph;
    logic [2:0]      tbl_en, tbl_hl;
    logic [2:0]      step_next;
    logic            step_any;

    // Commutation table: phase index (0=A, 1=B, 2=C) of the high and low leg.
    always_comb begin
        hi_ph = 2'd0;
        lo_ph = 2'd1;
        case (step_idx_q)
            3'd0:    begin hi_ph = 2'd0; lo_ph = 2'd1; end
            3'd1:    begin hi_ph = 2'd0; lo_ph = 2'd2; end
            3'd2:    begin hi_ph = 2'd1; lo_ph = 2'd2; end
            3'd3:    begin hi_ph = 2'd1; lo_ph = 2'd0; end
            3'd4:    begin hi_ph = 2'd2; lo_ph = 2'd0; end
            3'd5:    begin hi_ph = 2'd2; lo_ph = 2'd1; end
            default: begin hi_ph = 2'd0; lo_ph = 2'd1; end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_phase
            assign tbl_en[gi] = (hi_ph == 2'(gi)) || (lo_ph == 2'(gi));
            assign tbl_hl[gi] = (hi_ph == 2'(gi));
        end
    endgenerate

    // Step index wraps 5->0 going clockwise and 0->5 going counter-clockwise.
    assign step_next = dirCw ? ((step_idx_q == 3'd5) ? 3'd0 : step_idx_q + 3'd1)
                             : ((step_idx_q == 3'd0) ? 3'd5 : step_idx_q - 3'd1);

`ifdef MOTORO3_STEP_TIMER_EN
    logic [15:0] per_cnt_q, per_cnt_d;
    logic        auto_step;

    assign auto_step = (state_q == S_DRIVE) && (stepPeriod != 16'd0) &&
                       (per_cnt_q == stepPeriod - 16'd1);
    assign step_any  = stepReq | auto_step;
`else
    assign step_any  = stepReq;
`endif

    always_comb begin
        state_d     = state_q;
        dead_cnt_d  = dead_cnt_q;
        step_idx_d  = step_idx_q;
        ph_enable_d = ph_enable_q;
        ph_h1l0_d   = ph_h1l0_q;

        if (fault) begin
            state_d     = S_FAULT;
            dead_cnt_d  = '0;
            ph_enable_d = 3'b000;
            ph_h1l0_d   = 3'b000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ph_enable_d = 3'b000;
                    ph_h1l0_d   = 3'b000;
                    if (!stop && start) begin
                        state_d    = S_DEAD;
                        dead_cnt_d = DT_LOAD;
                    end
                end
                S_DEAD: begin
                    ph_enable_d = 3'b000;
                    if (stop) begin
                        state_d    = S_IDLE;
                        dead_cnt_d = '0;
                        ph_h1l0_d  = 3'b000;
                    end else if (dead_cnt_q == '0) begin
                        state_d     = S_DRIVE;
                        ph_enable_d = tbl_en;
                        ph_h1l0_d   = tbl_hl;
                    end else begin
                        dead_cnt_d = dead_cnt_q - 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (stop) begin
                        state_d     = S_IDLE;
                        ph_enable_d = 3'b000;
                        ph_h1l0_d   = 3'b000;
                    end else if (step_any) begin
                        // phH1L0 keeps the old pattern through the dead interval.
                        state_d     = S_DEAD;
                        step_idx_d  = step_next;
                        dead_cnt_d  = DT_LOAD;
                        ph_enable_d = 3'b000;
                    end
                end
                S_FAULT: begin
                    ph_enable_d = 3'b000;
                    ph_h1l0_d   = 3'b000;
                    if (faultClr) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    ph_enable_d = 3'b000;
                    ph_h1l0_d   = 3'b000;
                end
            endcase
        end

        busy_d          = (state_d == S_DEAD) || (state_d == S_DRIVE);
        fault_latched_d = (state_d == S_FAULT);
    end

`ifdef MOTORO3_STEP_TIMER_EN
    // Runs only while staying in DRIVE; entry, steps and other states clear it.
    always_comb begin
        per_cnt_d = 16'd0;
        if (state_q == S_DRIVE && state_d == S_DRIVE) begin
            per_cnt_d = per_cnt_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            dead_cnt_q      <= '0;
            step_idx_q      <= 3'd0;
            ph_enable_q     <= 3'b000;
            ph_h1l0_q       <= 3'b000;
            busy_q          <= 1'b0;
            fault_latched_q <= 1'b0;
`ifdef MOTORO3_STEP_TIMER_EN
            per_cnt_q       <= 16'd0;
`endif
        end else begin
            state_q         <= state_d;
            dead_cnt_q      <= dead_cnt_d;
            step_idx_q      <= step_idx_d;
            ph_enable_q     <= ph_enable_d;
            ph_h1l0_q       <= ph_h1l0_d;
            busy_q          <= busy_d;
            fault_latched_q <= fault_latched_d;
`ifdef MOTORO3_STEP_TIMER_EN
            per_cnt_q       <= per_cnt_d;
`endif
        end
    end

    assign phEnable     = ph_enable_q;
    assign phH1L0       = ph_h1l0_q;
    assign stepIdx      = step_idx_q;
    assign busy         = busy_q;
    assign faultLatched = fault_latched_q;

endmodule
